// File: rtl/avalon_pio_cmd_master_if.sv
// Avalon-MM bus between the PIO command master and its slaves.
// Uses chipselect with active-low read/write strobes, as PIO-style slaves expect.
interface avalon_pio_cmd_master_if #(
    parameter int ADDR_W = 3,
    parameter int DATA_W = 32
) ();
    logic              chipselect;
    logic              read_n;
    logic              write_n;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] writedata;
    logic [DATA_W-1:0] readdata;
    logic              waitrequest;

    modport master (
        output chipselect, read_n, write_n, address, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  chipselect, read_n, write_n, address, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/avalon_pio_cmd_master.sv
// Avalon-MM command master: read, write and non-atomic set/clear-bits RMW on PIO slaves.
// Define AVALON_PIO_CMD_MASTER_TIMEOUT_EN to abort requests stalled by waitrequest.
module avalon_pio_cmd_master #(
    parameter int ADDR_W         = 3,
    parameter int DATA_W         = 32,
    parameter int READ_LATENCY   = 1,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [1:0]                  cmd_op,
    input  logic [ADDR_W-1:0]           cmd_address,
    input  logic [DATA_W-1:0]           cmd_writedata,
    output logic                        rsp_valid,
    output logic [DATA_W-1:0]           rsp_readdata,
    output logic                        rsp_error,
    avalon_pio_cmd_master_if.master     avm
);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, RSP} state_t;
    typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_SET, OP_CLR} op_t;

    localparam logic [2:0] READ_LAT = READ_LATENCY[2:0];

    state_t            state, state_next;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic [DATA_W-1:0] rd_q;
    logic [DATA_W-1:0] rsp_data_q;
    logic [DATA_W-1:0] rsp_data_next;
    logic [2:0]        lat_cnt;
    logic              out_of_reset;
    logic              cmd_fire;
    logic              rd_sample;
    logic              rsp_load;
    logic              to_abort;

    // cmd_ready stays low until the first edge after reset releases.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) out_of_reset <= 1'b0;
        else          out_of_reset <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        // NOTE: defaults first so no path through the case infers a latch.
        state_next = state;
        unique case (state)
            IDLE: begin
                if (cmd_fire)
                    state_next = (op_t'(cmd_op) == OP_WRITE) ? WR_REQ : RD_REQ;
            end
            RD_REQ: begin
                if (!avm.waitrequest) state_next = RD_WAIT;
                else if (to_abort)    state_next = RSP;
            end
            RD_WAIT: begin
                if (lat_cnt == READ_LAT)
                    state_next = (op_q == OP_READ) ? RSP : WR_REQ;
            end
            WR_REQ: begin
                if (!avm.waitrequest || to_abort) state_next = RSP;
            end
            RSP:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE) && out_of_reset;
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rd_sample = (state == RD_WAIT) && (lat_cnt == READ_LAT);
    assign rsp_load  = (state != RSP) && (state_next == RSP);

    // Aborted requests and plain writes report zero; a plain read reports the bus
    // value directly, an RMW reports the value it read before modifying it.
    always_comb begin
        rsp_data_next = '0;
        if (!to_abort && op_q != OP_WRITE)
            rsp_data_next = (state == RD_WAIT) ? avm.readdata : rd_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_q       <= OP_READ;
            addr_q     <= '0;
            data_q     <= '0;
            rd_q       <= '0;
            lat_cnt    <= '0;
            rsp_data_q <= '0;
        end else begin
            // NOTE: registers use <= so every flop samples pre-edge values.
            if (cmd_fire) begin
                op_q   <= op_t'(cmd_op);
                addr_q <= cmd_address;
                data_q <= cmd_writedata;
            end
            if (rd_sample) begin
                rd_q <= avm.readdata;
                if (op_q == OP_SET) data_q <= avm.readdata | data_q;
                if (op_q == OP_CLR) data_q <= avm.readdata & ~data_q;
            end
            if (state == RD_WAIT && state_next == RD_WAIT) lat_cnt <= lat_cnt + 3'd1;
            else if (state == RD_REQ && state_next == RD_WAIT) lat_cnt <= 3'd1;
            else lat_cnt <= '0;
            if (rsp_load) rsp_data_q <= rsp_data_next;
        end
    end

`ifdef AVALON_PIO_CMD_MASTER_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] to_cnt;
    logic        req_stalled;
    logic        err_q;

    assign req_stalled = (state == RD_REQ || state == WR_REQ) && avm.waitrequest;
    assign to_abort    = req_stalled && (to_cnt == TO_LAST);

    // Counts consecutive stalled cycles; any state change clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            to_cnt <= '0;
            err_q  <= 1'b0;
        end else begin
            if (req_stalled && !to_abort) to_cnt <= to_cnt + 16'd1;
            else                          to_cnt <= '0;
            if (to_abort)          err_q <= 1'b1;
            else if (state == RSP) err_q <= 1'b0;
        end
    end

    assign rsp_error = err_q;
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
    assign to_abort           = 1'b0;
    assign rsp_error          = 1'b0;
`endif

    assign rsp_valid    = (state == RSP);
    assign rsp_readdata = rsp_data_q;

    // Strobes are decoded from disjoint states, so they can never both be low.
    assign avm.chipselect = (state == RD_REQ) || (state == WR_REQ);
    assign avm.read_n     = (state != RD_REQ);
    assign avm.write_n    = (state != WR_REQ);
    assign avm.address    = addr_q;
    assign avm.writedata  = data_q;

endmodule
